// File: rtl/pifo_calendar_pkg.sv
// Shared widths, pifo_info field positions and types for the root PIFO calendar blocks.
package pifo_calendar_pkg;

  localparam int unsigned BUFFER_ADDR_WIDTH = 12;
  localparam int unsigned PIFO_RANK_WIDTH   = 18;
  localparam int unsigned PIFO_ROOT_WIDTH   = 32;

  localparam int unsigned VALID_POS      = 31;
  localparam int unsigned OVERFLOW_POS   = 30;
  localparam int unsigned RANK_START_POS = 12;
  localparam int unsigned RANK_END_POS   = 29;

  typedef struct packed {
    logic                         valid;
    logic                         overflow;
    logic [PIFO_RANK_WIDTH-1:0]   rank;
    logic [BUFFER_ADDR_WIDTH-1:0] addr;
  } pifo_info_t;

  typedef struct packed {
    logic [PIFO_RANK_WIDTH-1:0]   rank;
    logic [BUFFER_ADDR_WIDTH-1:0] addr;
  } enq_desc_t;

  localparam int unsigned ENQ_DESC_WIDTH = PIFO_RANK_WIDTH + BUFFER_ADDR_WIDTH;

  typedef enum logic [0:0] {
    StIdle,
    StIssue
  } enq_state_e;

  // A rank below the last dequeued rank has wrapped into the next epoch.
  function automatic logic rank_overflow(input logic [PIFO_RANK_WIDTH-1:0] rank,
                                         input logic [PIFO_RANK_WIDTH-1:0] base_rank,
                                         input logic                       base_ovf);
    return (rank < base_rank) ? ~base_ovf : base_ovf;
  endfunction

endpackage

// File: rtl/pifo_enq_desc_fifo.sv
// Single-clock descriptor FIFO with async active-low reset; exposes full, empty and count.
module pifo_enq_desc_fifo #(
  parameter int unsigned DATA_WIDTH = 30,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_wr, do_rd;

  assign full    = (count_q == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pifo_calendar_enq_ctrl.sv
// Enqueue front-end for the root PIFO calendar: buffers descriptors and issues pifo_info inserts.
// Optional PIFO_ENQ_DROP_EN: accept always, drop on full FIFO and count drops.
module pifo_calendar_enq_ctrl
  import pifo_calendar_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned FIFO_ADDR_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         s_desc_valid,
  output logic                         s_desc_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_desc_addr,
  input  logic [PIFO_RANK_WIDTH-1:0]   s_desc_rank,
  output logic [PIFO_ROOT_WIDTH-1:0]   m_pifo_info,
  output logic                         m_insert_en,
  input  logic                         cal_full,
  input  logic                         cal_pop_en,
  input  logic [PIFO_ROOT_WIDTH-1:0]   cal_top
`ifdef PIFO_ENQ_DROP_EN
  ,
  output logic [15:0]                  drop_count
`endif
);

  enq_state_e                 state_q, state_d;
  enq_desc_t                  wr_desc, head;
  pifo_info_t                 top, info_q, info_d;
  logic                       insert_en_q;
  logic [PIFO_RANK_WIDTH-1:0] base_rank_q;
  logic                       base_ovf_q;
  logic                       fifo_full, fifo_empty, fifo_wr, issue;
  logic [FIFO_ADDR_WIDTH:0]   fifo_count;
  logic                       unused_fifo_count;

  assign wr_desc           = '{rank: s_desc_rank, addr: s_desc_addr};
  assign fifo_wr           = s_desc_valid && !fifo_full;
  assign top               = pifo_info_t'(cal_top);
  assign unused_fifo_count = ^fifo_count;

`ifdef PIFO_ENQ_DROP_EN
  logic [15:0] drop_count_q;

  assign s_desc_ready = 1'b1;
  assign drop_count   = drop_count_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_count_q <= '0;
    end else if (s_desc_valid && fifo_full && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end
`else
  assign s_desc_ready = !fifo_full;
`endif

  pifo_enq_desc_fifo #(
    .DATA_WIDTH (ENQ_DESC_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fifo_wr),
    .wr_data (wr_desc),
    .rd_en   (issue),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // StIssue is the hold cycle: cal_full lags the calendar count by one cycle.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    info_d  = info_q;
    unique case (state_q)
      StIdle: begin
        issue = !fifo_empty && !cal_full;
        if (issue) begin
          state_d = StIssue;
          info_d  = '{valid:    1'b1,
                      overflow: rank_overflow(head.rank, base_rank_q, base_ovf_q),
                      rank:     head.rank,
                      addr:     head.addr};
        end
      end
      StIssue: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      insert_en_q <= 1'b0;
      info_q      <= '0;
    end else begin
      state_q     <= state_d;
      insert_en_q <= issue;
      info_q      <= info_d;
    end
  end

  // Only a pop of a valid top moves the epoch reference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_rank_q <= '0;
      base_ovf_q  <= 1'b0;
    end else if (cal_pop_en && top.valid) begin
      base_rank_q <= top.rank;
      base_ovf_q  <= top.overflow;
    end
  end

  assign m_insert_en = insert_en_q;
  assign m_pifo_info = info_q;

endmodule
